// File: rtl/rf_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_arbiter_pkg
// Shared types and constants for the two-client register-file arbiter.
//   state_e      : top-level sequencer state (INIT sweep, then RUN).
//   CLI0 / CLI1  : client indices, also the encoding of the round-robin pointer.
//   DEF_*        : default geometry used when the top is instantiated bare.
// -----------------------------------------------------------------------------
package rf_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic CLI0 = 1'b0;
    localparam logic CLI1 = 1'b1;

    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 2;

endpackage

// File: rtl/rf_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_arbiter_if
// Client-side bus of the register-file arbiter, both clients in one bundle.
//   reqK / weK / addrK / wdataK : request from client K (master -> slave)
//   gntK                        : combinational grant      (slave -> master)
//   rvalidK / rdataK            : registered read return   (slave -> master)
//   init_done                   : storage sweep finished   (slave -> master)
//
// Handshake: a client raises reqK with weK/addrK/wdataK stable and holds them
// until it sees gntK high; the access is accepted on the clock edge that ends
// a cycle in which reqK & gntK. gntK never rises without reqK and at most one
// gnt is high per cycle. A granted read returns exactly one cycle later as a
// single-cycle rvalidK pulse; rdataK keeps its last value while rvalidK is low.
// -----------------------------------------------------------------------------
interface rf_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              init_done;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done
    );
endinterface

// File: rtl/rf_core.sv
// -----------------------------------------------------------------------------
// rf_core
// NUM_REGS x DATA_W register array, one write port and one synchronous read
// port with one cycle of latency.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write port; writes to addresses >= NUM_REGS are dropped
//   rd_en_i/raddr_i   : read port; the word is captured when rd_en_i is high
//   rdata_o           : registered read data; 0 for addresses >= NUM_REGS
// The array itself has no reset: the owner is expected to sweep it.
// -----------------------------------------------------------------------------
module rf_core #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rd_word;

    // Address decode by comparison against each entry: an address with no
    // matching entry simply hits nothing, which drops writes and reads 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we_i && (waddr_i == ADDR_W'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_i == ADDR_W'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_word;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rf_arbiter.sv
// -----------------------------------------------------------------------------
// rf_arbiter
// Shares one rf_core between two clients, one access per cycle, round-robin.
// After reset an INIT sweep writes zero to every register (one per cycle);
// only then does the block enter RUN and start granting.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : rf_arbiter_if slave side (requests in; grants, read
//                  returns and init_done out)
//   dbg_state_o  : current sequencer state, for observation only
// -----------------------------------------------------------------------------
module rf_arbiter
    import rf_arbiter_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    rf_arbiter_if.slave  bus,
    output state_e       dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    // Sequencer state
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;

    // Arbitration / read-return state
    logic              rr_last_q, rr_last_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] hold0_q, hold1_q;

    // Combinational outputs of the sequencer
    logic              run;
    logic              gnt0, gnt1;
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_rd_en;
    logic [ADDR_W-1:0] core_raddr;
    logic [DATA_W-1:0] core_rdata;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        unique case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_REG) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        run = (state_q == ST_RUN);

        // A lone request wins; on contention the client that was not served
        // last goes first.
        gnt0 = run && bus.req0 && (!bus.req1 || (rr_last_q == CLI1));
        gnt1 = run && bus.req1 && (!bus.req0 || (rr_last_q == CLI0));

        // During INIT the sweep owns the write port; in RUN the granted
        // client does.
        if (run) begin
            core_we    = (gnt0 && bus.we0) || (gnt1 && bus.we1);
            core_waddr = gnt1 ? bus.addr1  : bus.addr0;
            core_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
        end else begin
            core_we    = 1'b1;
            core_waddr = init_ptr_q;
            core_wdata = '0;
        end

        core_rd_en = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
        core_raddr = gnt1 ? bus.addr1 : bus.addr0;

        rvalid0_d  = gnt0 && !bus.we0;
        rvalid1_d  = gnt1 && !bus.we1;

        rr_last_d  = rr_last_q;
        if (gnt0) begin
            rr_last_d = CLI0;
        end else if (gnt1) begin
            rr_last_d = CLI1;
        end
    end

    // ---------------- arbitration / return registers ----------------
    // rr_last resets to CLI1 so client 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= CLI1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            if (rvalid0_q) begin
                hold0_q <= core_rdata;
            end
            if (rvalid1_q) begin
                hold1_q <= core_rdata;
            end
        end
    end

    rf_core #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we_i    (core_we),
        .waddr_i (core_waddr),
        .wdata_i (core_wdata),
        .rd_en_i (core_rd_en),
        .raddr_i (core_raddr),
        .rdata_o (core_rdata)
    );

    // The core's read register is shared, so each client keeps its own copy
    // of the last word it was given; the fresh core word is shown during the
    // rvalid cycle and the copy afterwards.
    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rvalid0_q ? core_rdata : hold0_q;
    assign bus.rdata1    = rvalid1_q ? core_rdata : hold1_q;
    assign bus.init_done = run;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_arbiter
// Two instances share one stimulus stream: dut_a (4 registers) and dut_b
// (3 registers, so address 3 is out of range). A behavioural model per
// instance predicts every output each cycle; literal checks pin key results.
// -----------------------------------------------------------------------------
module tb_rf_arbiter;
    import rf_arbiter_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NR_A   = 4;
    localparam int NR_B   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    state_e            dbg_a, dbg_b;

    rf_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    rf_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

    assign bus_a.req0 = req0;     assign bus_b.req0 = req0;
    assign bus_a.req1 = req1;     assign bus_b.req1 = req1;
    assign bus_a.we0 = we0;       assign bus_b.we0 = we0;
    assign bus_a.we1 = we1;       assign bus_b.we1 = we1;
    assign bus_a.addr0 = addr0;   assign bus_b.addr0 = addr0;
    assign bus_a.addr1 = addr1;   assign bus_b.addr1 = addr1;
    assign bus_a.wdata0 = wdata0; assign bus_b.wdata0 = wdata0;
    assign bus_a.wdata1 = wdata1; assign bus_b.wdata1 = wdata1;

    rf_arbiter #(.NUM_REGS(NR_A), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .dbg_state_o(dbg_a)
    );
    rf_arbiter #(.NUM_REGS(NR_B), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .dbg_state_o(dbg_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc_no = -3;

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                     name, d, cyc_no, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: register contents, edges seen since reset, last client
    // served, and the read return each client currently shows.
    logic [DATA_W-1:0] mreg  [2][4];
    int                msince[2];
    int                mrr   [2];
    bit                mrv0  [2];
    bit                mrv1  [2];
    logic [DATA_W-1:0] mrd0  [2];
    logic [DATA_W-1:0] mrd1  [2];
    bit                model_ok = 1'b0;

    function automatic int nregs(input int d);
        return (d == 0) ? NR_A : NR_B;
    endfunction

    // Ready once one clean edge per register has passed since reset.
    function automatic bit mrun(input int d);
        return msince[d] >= nregs(d);
    endfunction

    task automatic mgrant(input int d, output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (mrun(d)) begin
            if (req0 && req1) begin
                if (mrr[d] == 1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    endtask

    task automatic maccess(input int d, input int k, input bit we,
                           input int a, input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] val;
        if (we) begin
            if (a < nregs(d)) mreg[d][a] = wd;
        end else begin
            val = (a < nregs(d)) ? mreg[d][a] : '0;
            if (k == 0) begin mrv0[d] = 1'b1; mrd0[d] = val; end
            else        begin mrv1[d] = 1'b1; mrd1[d] = val; end
        end
        mrr[d] = k;
    endtask

    // Advance the model across one rising edge using the inputs of the cycle
    // that edge ends.
    task automatic model_step();
        bit g0, g1;
        for (int d = 0; d < 2; d++) begin
            mgrant(d, g0, g1);
            if (rst) begin
                msince[d] = 0;
                for (int i = 0; i < 4; i++) mreg[d][i] = '0;
                mrr[d]  = 1;
                mrv0[d] = 1'b0; mrv1[d] = 1'b0;
                mrd0[d] = '0;   mrd1[d] = '0;
            end else begin
                mrv0[d] = 1'b0;
                mrv1[d] = 1'b0;
                if (g0) maccess(d, 0, we0, int'(addr0), wdata0);
                if (g1) maccess(d, 1, we1, int'(addr1), wdata1);
                if (msince[d] < nregs(d)) msince[d]++;
            end
        end
        if (rst) model_ok = 1'b1;
    endtask

    task automatic compare_dut(input int d, input logic g0, input logic g1,
                               input logic rv0, input logic rv1,
                               input logic [DATA_W-1:0] rd0,
                               input logic [DATA_W-1:0] rd1,
                               input logic idn, input state_e st);
        bit e0, e1;
        mgrant(d, e0, e1);
        check("gnt0", d, 32'(g0), 32'(e0));
        check("gnt1", d, 32'(g1), 32'(e1));
        check("rvalid0", d, 32'(rv0), 32'(mrv0[d]));
        check("rvalid1", d, 32'(rv1), 32'(mrv1[d]));
        check("rdata0", d, 32'(rd0), 32'(mrd0[d]));
        check("rdata1", d, 32'(rd1), 32'(mrd1[d]));
        check("init_done", d, 32'(idn), 32'(mrun(d)));
        check("state", d, 32'(st), mrun(d) ? 32'(ST_RUN) : 32'(ST_INIT));
    endtask

    // Compare process: every cycle once the model has seen a reset edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                compare_dut(0, bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1,
                            bus_a.rdata0, bus_a.rdata1, bus_a.init_done, dbg_a);
                compare_dut(1, bus_b.gnt0, bus_b.gnt1, bus_b.rvalid0, bus_b.rvalid1,
                            bus_b.rdata0, bus_b.rdata1, bus_b.init_done, dbg_b);
            end
        end
    end

    // ---------------- driver ----------------
    // One call = one clock cycle: the model crosses the edge, the new inputs
    // are applied just after it, and control returns at the falling edge.
    task automatic cyc(input bit r,
                       input bit q0, input bit w0, input int a0, input int d0,
                       input bit q1, input bit w1, input int a1, input int d1);
        @(posedge clk);
        model_step();
        #1;
        rst = r;
        req0 = q0; we0 = w0; addr0 = ADDR_W'(a0); wdata0 = DATA_W'(d0);
        req1 = q1; we1 = w1; addr1 = ADDR_W'(a1); wdata1 = DATA_W'(d1);
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle(1);
        idle(1);
        // cycle 0..3: INIT sweep, client 0 already asking
        for (int c = 0; c < 4; c++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
            check("lit_init_gnt0", 0, 32'(bus_a.gnt0), 0);
            check("lit_init_done_lo", 0, 32'(bus_a.init_done), 0);
        end
        // cycle 4..7: contention, reads of every address, expect 0,1,0,1
        cyc(0, 1, 0, 0, 0, 1, 0, 1, 0);
        check("lit_init_done_hi", 0, 32'(bus_a.init_done), 1);
        check("lit_cont_g0_c4", 0, 32'(bus_a.gnt0), 1);
        cyc(0, 1, 0, 2, 0, 1, 0, 1, 0);
        check("lit_cont_g1_c5", 0, 32'(bus_a.gnt1), 1);
        check("lit_rv0_c5", 0, 32'(bus_a.rvalid0), 1);
        cyc(0, 1, 0, 2, 0, 1, 0, 3, 0);
        check("lit_cont_g0_c6", 0, 32'(bus_a.gnt0), 1);
        check("lit_rv1_c6", 0, 32'(bus_a.rvalid1), 1);
        cyc(0, 1, 0, 0, 0, 1, 0, 3, 0);
        check("lit_cont_g1_c7", 0, 32'(bus_a.gnt1), 1);
        idle(0);
        check("lit_rd1_zero", 0, 32'(bus_a.rdata1), 0);
        // write then read by client 0
        cyc(0, 1, 1, 2, 8'hA5, 0, 0, 0, 0);
        cyc(0, 1, 0, 2, 0, 0, 0, 0, 0);
        idle(0);
        check("lit_rv0_a5", 0, 32'(bus_a.rvalid0), 1);
        check("lit_rd0_a5", 0, 32'(bus_a.rdata0), 32'hA5);
        check("lit_rv1_quiet", 0, 32'(bus_a.rvalid1), 0);
        idle(0);
        check("lit_rd0_hold", 0, 32'(bus_a.rdata0), 32'hA5);
        // cross-client visibility
        cyc(0, 0, 0, 0, 0, 1, 1, 1, 8'h3C);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        idle(0);
        check("lit_rd0_3c", 0, 32'(bus_a.rdata0), 32'h3C);
        // address 3: in range for dut_a, out of range for dut_b
        cyc(0, 0, 0, 0, 0, 1, 1, 3, 8'hEE);
        cyc(0, 0, 0, 0, 0, 1, 0, 3, 0);
        idle(0);
        check("lit_oor_rv1", 1, 32'(bus_b.rvalid1), 1);
        check("lit_oor_rd1", 1, 32'(bus_b.rdata1), 0);
        check("lit_inr_rd1", 0, 32'(bus_a.rdata1), 32'hEE);
        // contention write (client 0) vs read (client 1) of the same register
        cyc(0, 1, 1, 0, 8'h5A, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0);
        check("lit_wr_then_rd", 0, 32'(bus_a.rdata1), 32'h5A);
        // reset in the middle of operation
        cyc(0, 1, 1, 0, 8'h77, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        check("lit_pre_rst_rd1", 0, 32'(bus_a.rdata1), 32'h77);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
            check("lit_reinit_lo", 0, 32'(bus_a.init_done), 0);
            check("lit_reinit_gnt0", 0, 32'(bus_a.gnt0), 0);
            if (c == 0) check("lit_rv1_cancel", 0, 32'(bus_a.rvalid1), 0);
        end
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_reinit_hi", 0, 32'(bus_a.init_done), 1);
        idle(0);
        check("lit_rezero_rv0", 0, 32'(bus_a.rvalid0), 1);
        check("lit_rezero_rd0", 0, 32'(bus_a.rdata0), 0);
        // fill every register from client 0, read back from client 1,
        // overlapping so each read competes with the next write
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, i, 8'h10 + i, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, i, 8'hC0 + i, 1, 0, 3 - i, 0);
            cyc(0, 0, 0, 0, 0, 1, 0, 3 - i, 0);
        end
        idle(0);
        idle(0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Shares one small register file between two requesters (client 0, client 1): one access (read or write) per cycle.
- Round-robin arbitration; registered read data with 1-cycle latency.
- After reset, an init sequencer zeroes every register before granting any access.
- Storage lives in a sub-module; this block owns sequencing, arbitration and read-return routing.

Parameters:
- NUM_REGS, 4, number of registers (2..16, need not be a power of 2).
- DATA_W, 8, register width in bits.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; valid with req.
- addr0 / addr1  in  ADDR_W  register index.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational grant; req & gnt = access accepted this cycle.
- rvalid0 / rvalid1  out  1  registered; read data valid for that client.
- rdata0 / rdata1  out  DATA_W  registered read data.
- init_done  out  1  high once the init sweep completes.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - gnt0/1 = 0 (forced low while not RUN).
  - rvalid0/1 = 0.
  - rdata0/1 = 0.
  - init_done = 0.
  - rr_last = 1, so client 0 wins the first contest.
  - FSM = INIT, init_ptr = 0.
- FSM INIT:
  - Writes 0 to register init_ptr each cycle and increments init_ptr.
  - On the write to NUM_REGS-1, moves to RUN next cycle; init_done = 1 from that cycle on.
  - INIT takes exactly NUM_REGS cycles after rst deasserts.
- FSM RUN stays in RUN until rst.
- Arbitration (RUN only):
  - Only one req high: that client is granted.
  - Both high: grant the client not equal to rr_last.
  - rr_last updates to the granted client on every grant.
  - At most one gnt per cycle; no grant without req.
- Write: on gnt with we = 1, register[addr] <= wdata at that clock edge.
- Read:
  - On gnt with we = 0, the next cycle shows rdata_k = register[addr] and rvalid_k = 1 for exactly one cycle; the other client's rvalid stays 0.
  - rdata_k holds its last value when rvalid_k = 0.
- Ordering:
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later.
  - No same-cycle read/write conflict is possible: one access per cycle.
- Out-of-range address (addr >= NUM_REGS):
  - Still granted and consumes a slot.
  - Writes are dropped.
  - Reads return rvalid = 1 with rdata = 0.
- Reset during RUN:
  - Pending rvalid is cancelled (0 next cycle).
  - FSM returns to INIT and re-zeroes all registers.
  - Requests are ignored until init_done.
- Reset during INIT restarts the sweep at init_ptr = 0.

Decomposition:
- Package rf_arbiter_pkg:
  - state enum {ST_INIT, ST_RUN}.
  - Client index constants CLI0 = 0, CLI1 = 1.
  - Default NUM_REGS/DATA_W localparams.
- Sub-module rf_core:
  - Parameterized NUM_REGS × DATA_W array.
  - One write port (we, waddr, wdata).
  - One synchronous read port (raddr, rd_en, rdata registered, 1-cycle latency).
  - Out-of-range handling inside rf_core.
- rf_arbiter instantiates one rf_core and muxes the INIT sweep onto its write port.

Test Plan:
- Reset sweep: NUM_REGS = 4, deassert rst at cycle 0 → init_done rises at cycle 4; no gnt in cycles 0-3 despite req0 = 1; then read each of addr 0..3 → rdata = 0x00.
- Write then read: client 0 writes 0xA5 to addr 2 in cycle N, reads addr 2 in N+1 → rvalid0 = 1, rdata0 = 0xA5 in N+2; rvalid1 stays 0.
- Contention: req0 = req1 = 1 held for 4 cycles after init → grant sequence 0,1,0,1; each read result is returned only on the matching rvalid.
- Cross-client visibility: client 1 writes 0x3C to addr 1, client 0 then reads addr 1 → rdata0 = 0x3C; client 1 writes to addr 3 with NUM_REGS = 3 → dropped; read of addr 3 → rdata = 0x00, rvalid = 1.
- Reset mid-operation: grant a read to client 1, assert rst the next cycle → rvalid1 = 0; init_done = 0 for 4 cycles; a prior value 0x77 at addr 0 reads back 0x00 after re-init.
